// File: rtl/sample_rate_pkg.sv
// sample_rate_pkg: state encoding, decade constants and command-word layout
// shared by the sample strobe generator and its decade counters.
package sample_rate_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SWITCH = 2'd2
    } srg_state_t;

    localparam int DECADE       = 10;
    localparam int DIGIT_W      = 4;
    localparam int CMD_RATE_LSB = 0;

    // The run flag sits directly above the rate index in cmd.
    function automatic int cmd_run_pos(input int sel_w);
        return sel_w;
    endfunction

endpackage

// File: rtl/decade_counter.sv
// decade_counter: one divide-by-10 prescaler digit with synchronous clear.
// carry_out is asserted when the digit wraps on this cycle's carry_in.
module decade_counter
    import sample_rate_pkg::*;
(
    input  logic               CLKin,
    input  logic               RSTn,
    input  logic               clear,
    input  logic               carry_in,
    output logic               carry_out,
    output logic [DIGIT_W-1:0] count
);

    localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(DECADE - 1);

    logic [DIGIT_W-1:0] count_reg;
    logic [DIGIT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (carry_in) begin
            count_next = (count_reg == LAST_DIGIT) ? '0 : count_reg + 1'b1;
        end
    end

    always_ff @(posedge CLKin or negedge RSTn) begin
        if (!RSTn) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign carry_out = carry_in && (count_reg == LAST_DIGIT);
    assign count     = count_reg;

endmodule

// File: rtl/sample_rate_gen.sv
// sample_rate_gen: decade-rate clock-enable strobe with rotating phase index.
// Define SRG_EXT_CLK_EN to add an external sample-clock mode at rate index STAGES+1.
module sample_rate_gen
    import sample_rate_pkg::*;
#(
    parameter int STAGES  = 6,
    parameter int PHASES  = 3,
    parameter int SEL_W   = $clog2(STAGES + 2),
    parameter int PHASE_W = $clog2(PHASES)
) (
    input  logic               CLKin,
    input  logic               RSTn,
    input  logic [SEL_W:0]     cmd,
    input  logic               wcmd,
    input  logic               ext_clk,
    output logic               sample_en,
    output logic [PHASE_W-1:0] phase,
    output logic               active,
    output logic [SEL_W-1:0]   rate_cur
);

    localparam int RUN_POS = cmd_run_pos(SEL_W);
`ifdef SRG_EXT_CLK_EN
    localparam int MAX_IDX = STAGES + 1;
    localparam logic [SEL_W-1:0] EXT_IDX = SEL_W'(STAGES + 1);
`else
    localparam int MAX_IDX = STAGES;
`endif
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PHASES - 1);
    localparam logic [DIGIT_W-1:0] DIGIT_8    = DIGIT_W'(DECADE - 2);
    localparam logic [DIGIT_W-1:0] DIGIT_9    = DIGIT_W'(DECADE - 1);

    function automatic logic [SEL_W-1:0] clamp_rate(input logic [SEL_W-1:0] idx);
        if (int'(idx) > MAX_IDX) begin
            return SEL_W'(MAX_IDX);
        end
        return idx;
    endfunction

    srg_state_t         state_reg, state_next;
    logic [SEL_W-1:0]   rate_reg, rate_next;
    logic [SEL_W-1:0]   pend_reg, pend_next;
    logic [PHASE_W-1:0] phase_reg, phase_next;
    logic               sample_en_reg, sample_en_next;
    logic               active_reg;
    logic               cmd_run;
    logic [SEL_W-1:0]   cmd_rate;
    logic               pre_clear, pre_advance;
    logic               ext_sel, ext_rise, nine_sel;
    logic [DIGIT_W-1:0] digit [STAGES];
    logic [STAGES-1:0]  carry;
    logic [STAGES:1]    pre9;
    logic               last_carry_unused;

    assign cmd_run  = cmd[RUN_POS];
    assign cmd_rate = clamp_rate(cmd[RUN_POS-1:CMD_RATE_LSB]);

    assign pre_advance = (state_reg != IDLE);
    assign carry[0]    = pre_advance;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic carry_out_w;
        decade_counter u_digit (
            .CLKin    (CLKin),
            .RSTn     (RSTn),
            .clear    (pre_clear),
            .carry_in (carry[gi]),
            .carry_out(carry_out_w),
            .count    (digit[gi])
        );
        if (gi < STAGES - 1) begin : g_chain
            assign carry[gi + 1] = carry_out_w;
        end else begin : g_last
            assign last_carry_unused = carry_out_w;
        end
    end

    // pre9[k]: stages 1..k will all read 9 once this cycle's advance lands,
    // so the registered strobe lines up with the all-nines prescaler state.
    always_comb begin
        pre9    = '0;
        pre9[1] = (digit[0] == DIGIT_8);
        for (int k = 2; k <= STAGES; k++) begin
            pre9[k] = pre9[k-1] && (digit[k-1] == DIGIT_9);
        end
    end

`ifdef SRG_EXT_CLK_EN
    logic ext_sync1_reg, ext_sync2_reg, ext_prev_reg;

    always_ff @(posedge CLKin or negedge RSTn) begin
        if (!RSTn) begin
            ext_sync1_reg <= 1'b0;
            ext_sync2_reg <= 1'b0;
            ext_prev_reg  <= 1'b0;
        end else begin
            ext_sync1_reg <= ext_clk;
            ext_sync2_reg <= ext_sync1_reg;
            ext_prev_reg  <= ext_sync2_reg;
        end
    end

    assign ext_rise = ext_sync2_reg && !ext_prev_reg;
`else
    logic ext_clk_unused;
    assign ext_clk_unused = ext_clk;
    assign ext_rise       = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        rate_next      = rate_reg;
        pend_next      = pend_reg;
        phase_next     = phase_reg;
        pre_clear      = 1'b0;
        ext_sel        = 1'b0;
        nine_sel       = 1'b0;
        sample_en_next = 1'b0;

        if (sample_en_reg) begin
            phase_next = (phase_reg == LAST_PHASE) ? '0 : phase_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (wcmd) begin
                    rate_next = cmd_rate;
                    if (cmd_run) begin
                        state_next = RUN;
                        phase_next = '0;
                    end
                end
            end
            RUN: begin
                if (wcmd) begin
                    if (!cmd_run) begin
                        state_next = IDLE;
                    end else if (cmd_rate != rate_reg) begin
                        state_next = SWITCH;
                        pend_next  = cmd_rate;
                    end
                end
            end
            SWITCH: begin
                // A command in the strobe cycle wins; its rate waits for the next strobe.
                if (wcmd) begin
                    if (!cmd_run) begin
                        state_next = IDLE;
                    end else begin
                        pend_next = cmd_rate;
                        if (cmd_rate == rate_reg) begin
                            state_next = RUN;
                        end
                    end
                end else if (sample_en_reg) begin
                    state_next = RUN;
                    rate_next  = pend_reg;
                    pre_clear  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

`ifdef SRG_EXT_CLK_EN
        ext_sel = (rate_next == EXT_IDX);
`endif
        if (state_next == IDLE || ext_sel) begin
            pre_clear = 1'b1;
        end

        for (int k = 1; k <= STAGES; k++) begin
            if (rate_next == SEL_W'(k)) begin
                nine_sel = pre9[k];
            end
        end

        if (state_next == IDLE) begin
            sample_en_next = 1'b0;
        end else if (ext_sel) begin
            sample_en_next = ext_rise;
        end else if (rate_next == '0) begin
            sample_en_next = 1'b1;
        end else begin
            sample_en_next = !pre_clear && nine_sel;
        end
    end

    always_ff @(posedge CLKin or negedge RSTn) begin
        if (!RSTn) begin
            state_reg     <= IDLE;
            rate_reg      <= '0;
            pend_reg      <= '0;
            phase_reg     <= '0;
            sample_en_reg <= 1'b0;
            active_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rate_reg      <= rate_next;
            pend_reg      <= pend_next;
            phase_reg     <= phase_next;
            sample_en_reg <= sample_en_next;
            active_reg    <= (state_next != IDLE);
        end
    end

    assign sample_en = sample_en_reg;
    assign phase     = phase_reg;
    assign active    = active_reg;
    assign rate_cur  = rate_reg;

endmodule
